vga_timing_gen: RTL and testbench

- Raster timing generator sitting directly downstream of the AXI4-Lite register slave in the reconfigurable VGA IP.
- Consumes the horizontal/vertical geometry and polarity fields that software writes through the slave registers.
- Produces HSYNC/VSYNC/DE plus pixel coordinates for the pixel-data and colour-output stage.
- Register fields are shadowed at frame boundaries, so software may rewrite geometry at any time without corrupting the frame in flight.

---
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: turns shadowed geometry/polarity fields into registered
// HSYNC/VSYNC/DE, active-area coordinates and frame/line start pulses.
module vga_timing_gen #(
    parameter int CNT_W = 12
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             pix_en,
    input  logic             enable,
    input  logic [CNT_W-1:0] h_active,
    input  logic [CNT_W-1:0] h_fp,
    input  logic [CNT_W-1:0] h_sync,
    input  logic [CNT_W-1:0] h_bp,
    input  logic [CNT_W-1:0] v_active,
    input  logic [CNT_W-1:0] v_fp,
    input  logic [CNT_W-1:0] v_sync,
    input  logic [CNT_W-1:0] v_bp,
    input  logic             h_pol,
    input  logic             v_pol,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             line_start,
    output logic             cfg_err,
    output logic             busy
);

    localparam int TW = CNT_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] ha;
        logic [CNT_W-1:0] hf;
        logic [CNT_W-1:0] hs;
        logic [CNT_W-1:0] hb;
        logic [CNT_W-1:0] va;
        logic [CNT_W-1:0] vf;
        logic [CNT_W-1:0] vs;
        logic [CNT_W-1:0] vb;
        logic             hp;
        logic             vp;
    } geom_t;

    state_t           state_q, state_d;
    geom_t            live_g, shd_q, shd_d;
    logic             live_ok;
    logic [TW-1:0]    hc_q, hc_d, vc_q, vc_d;
    logic [TW-1:0]    h_tot, v_tot;
    logic [TW-1:0]    h_act_end, h_sync_lo, h_sync_hi;
    logic [TW-1:0]    v_act_end, v_sync_lo, v_sync_hi;
    logic             h_last, v_last;
    logic             hsync_d, vsync_d, de_d, fs_d, ls_d, cfg_err_d, busy_d;
    logic [CNT_W-1:0] x_d, y_d;

    assign live_g  = {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, h_pol, v_pol};
    assign live_ok = (h_active != '0) && (h_fp != '0) && (h_sync != '0) && (h_bp != '0) &&
                     (v_active != '0) && (v_fp != '0) && (v_sync != '0) && (v_bp != '0);

    // Frame totals always come from the shadow so live rewrites cannot bend the current frame.
    assign h_tot  = {2'b00, shd_q.ha} + {2'b00, shd_q.hf} + {2'b00, shd_q.hs} + {2'b00, shd_q.hb};
    assign v_tot  = {2'b00, shd_q.va} + {2'b00, shd_q.vf} + {2'b00, shd_q.vs} + {2'b00, shd_q.vb};
    assign h_last = (hc_q == h_tot - 1'b1);
    assign v_last = (vc_q == v_tot - 1'b1);

    always_comb begin
        state_d   = state_q;
        shd_d     = shd_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        cfg_err_d = cfg_err;
        fs_d      = 1'b0;
        ls_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (live_ok) begin
                        state_d   = RUN;
                        shd_d     = live_g;
                        hc_d      = '0;
                        vc_d      = '0;
                        cfg_err_d = 1'b0;
                        fs_d      = 1'b1;
                        ls_d      = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (h_last) begin
                    hc_d = '0;
                    if (v_last) begin
                        vc_d = '0;
                        if (!enable) begin
                            state_d = IDLE;
                        end else if (!live_ok) begin
                            state_d   = IDLE;
                            cfg_err_d = 1'b1;
                        end else begin
                            shd_d = live_g;
                            fs_d  = 1'b1;
                            ls_d  = 1'b1;
                        end
                    end else begin
                        vc_d = vc_q + 1'b1;
                        ls_d = 1'b1;
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs describe the position about to be held, decoded with the shadow in force then.
        h_act_end = {2'b00, shd_d.ha};
        h_sync_lo = h_act_end + {2'b00, shd_d.hf};
        h_sync_hi = h_sync_lo + {2'b00, shd_d.hs};
        v_act_end = {2'b00, shd_d.va};
        v_sync_lo = v_act_end + {2'b00, shd_d.vf};
        v_sync_hi = v_sync_lo + {2'b00, shd_d.vs};

        if (state_d == RUN) begin
            de_d    = (hc_d < h_act_end) && (vc_d < v_act_end);
            hsync_d = ((hc_d >= h_sync_lo) && (hc_d < h_sync_hi)) ? shd_d.hp : ~shd_d.hp;
            vsync_d = ((vc_d >= v_sync_lo) && (vc_d < v_sync_hi)) ? shd_d.vp : ~shd_d.vp;
            busy_d  = 1'b1;
        end else begin
            de_d    = 1'b0;
            hsync_d = ~live_g.hp;
            vsync_d = ~live_g.vp;
            busy_d  = 1'b0;
        end
        x_d = de_d ? hc_d[CNT_W-1:0] : '0;
        y_d = de_d ? vc_d[CNT_W-1:0] : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            shd_q       <= '0;
            hc_q        <= '0;
            vc_q        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
        end else if (pix_en) begin
            state_q     <= state_d;
            shd_q       <= shd_d;
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            de          <= de_d;
            x           <= x_d;
            y           <= y_d;
            frame_start <= fs_d;
            line_start  <= ls_d;
            cfg_err     <= cfg_err_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a hand-computed vector table on the 8x6 raster
// plus short sequences for pixel enable, reconfiguration, errors, stop and reset.
module tb_vga_timing_gen;

    localparam int CNT_W = 12;

    logic             ACLK, ARESETN, pix_en, enable;
    logic [CNT_W-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CNT_W-1:0] v_active, v_fp, v_sync, v_bp;
    logic             h_pol, v_pol;
    logic             hsync, vsync, de, frame_start, line_start, cfg_err, busy;
    logic [CNT_W-1:0] x, y;

    vga_timing_gen #(.CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .pix_en(pix_en), .enable(enable),
        .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
        .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
        .h_pol(h_pol), .v_pol(v_pol),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .line_start(line_start),
        .cfg_err(cfg_err), .busy(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int cyc; int de; int hs; int vs; int fs; int ls; int x; int y;
    } vec_t;

    vec_t vecs[14];
    int   vec_count  = 0;
    int   miss_count = 0;

    int cap_de[0:127], cap_hs[0:127], cap_vs[0:127], cap_fs[0:127];
    int cap_ls[0:127], cap_x[0:127], cap_y[0:127], cap_busy[0:127];

    task automatic check_output(input string name, input int actual, input int expected);
        vec_count++;
        if (actual != expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb,
                                  input logic hp, input logic vp);
        h_active = CNT_W'(ha); h_fp = CNT_W'(hf); h_sync = CNT_W'(hs); h_bp = CNT_W'(hb);
        v_active = CNT_W'(va); v_fp = CNT_W'(vf); v_sync = CNT_W'(vs); v_bp = CNT_W'(vb);
        h_pol = hp; v_pol = vp;
    endtask

    task automatic do_step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        enable  = 1'b0;
        pix_en  = 1'b1;
        do_step();
        ARESETN = 1'b1;
    endtask

    task automatic sample(input int i);
        cap_de[i] = int'(de);   cap_hs[i] = int'(hsync); cap_vs[i] = int'(vsync);
        cap_fs[i] = int'(frame_start); cap_ls[i] = int'(line_start);
        cap_x[i]  = int'(x);    cap_y[i]  = int'(y);     cap_busy[i] = int'(busy);
    endtask

    // Starts a frame and records n consecutive pixels (index 0 = pixel (0,0)).
    task automatic capture(input int n);
        enable = 1'b1;
        do_step();
        for (int i = 0; i < n; i++) begin
            sample(i);
            if (i < n - 1) do_step();
        end
    endtask

    // Checks the 8x6 raster against the hand table and an independent position formula.
    task automatic check_raster(input logic hp, input logic vp);
        int hc, vc, exp_de, exp_hs, exp_vs, de_total;
        for (int k = 0; k < 14; k++) begin
            int c;
            c = vecs[k].cyc;
            check_output($sformatf("tbl%0d.de", c), cap_de[c], vecs[k].de);
            check_output($sformatf("tbl%0d.hs", c), cap_hs[c], hp ? vecs[k].hs : 1 - vecs[k].hs);
            check_output($sformatf("tbl%0d.vs", c), cap_vs[c], vp ? vecs[k].vs : 1 - vecs[k].vs);
            check_output($sformatf("tbl%0d.fs", c), cap_fs[c], vecs[k].fs);
            check_output($sformatf("tbl%0d.ls", c), cap_ls[c], vecs[k].ls);
            check_output($sformatf("tbl%0d.x", c),  cap_x[c],  vecs[k].x);
            check_output($sformatf("tbl%0d.y", c),  cap_y[c],  vecs[k].y);
        end
        de_total = 0;
        for (int i = 0; i < 48; i++) begin
            hc = i % 8;
            vc = i / 8;
            exp_de = (hc < 4 && vc < 3) ? 1 : 0;
            exp_hs = (hc == 5 || hc == 6) ? int'(hp) : 1 - int'(hp);
            exp_vs = (vc == 4) ? int'(vp) : 1 - int'(vp);
            check_output($sformatf("pix%0d.de", i), cap_de[i], exp_de);
            check_output($sformatf("pix%0d.hs", i), cap_hs[i], exp_hs);
            check_output($sformatf("pix%0d.vs", i), cap_vs[i], exp_vs);
            check_output($sformatf("pix%0d.x", i),  cap_x[i],  exp_de ? hc : 0);
            check_output($sformatf("pix%0d.y", i),  cap_y[i],  exp_de ? vc : 0);
            de_total += cap_de[i];
        end
        check_output("de_per_frame", de_total, 12);
    endtask

    initial begin
        int changes, cnt, fs_cnt;
        logic [31:0] snap, now_v;

        vecs[0]  = '{0, 1, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{3, 1, 0, 0, 0, 0, 3, 0};
        vecs[2]  = '{4, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{5, 0, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{6, 0, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{7, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{8, 1, 0, 0, 0, 1, 0, 1};
        vecs[7]  = '{18, 1, 0, 0, 0, 0, 2, 2};
        vecs[8]  = '{26, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{32, 0, 0, 1, 0, 1, 0, 0};
        vecs[10] = '{37, 0, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{40, 0, 0, 0, 0, 1, 0, 0};
        vecs[12] = '{47, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{48, 1, 0, 0, 1, 1, 0, 0};

        apply_stimulus(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        ARESETN = 1'b0; enable = 1'b0; pix_en = 1'b0;
        #12;
        check_output("rst.hsync", hsync, 0);
        check_output("rst.vsync", vsync, 0);
        check_output("rst.de", de, 0);
        check_output("rst.busy", busy, 0);
        check_output("rst.cfg_err", cfg_err, 0);
        check_output("rst.fs", frame_start, 0);
        check_output("rst.x", x, 0);

        $display("[TB] active-high raster");
        do_reset();
        capture(49);
        check_raster(1'b1, 1'b1);

        $display("[TB] active-low raster");
        do_reset();
        apply_stimulus(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        capture(49);
        check_raster(1'b0, 1'b0);

        $display("[TB] pixel enable one in three");
        do_reset();
        apply_stimulus(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        enable  = 1'b1;
        changes = 0;
        for (int k = 0; k <= 150; k++) begin
            pix_en = (k % 3 == 0);
            snap = {hsync, vsync, de, frame_start, line_start, cfg_err, busy, x, y, 1'b0};
            do_step();
            now_v = {hsync, vsync, de, frame_start, line_start, cfg_err, busy, x, y, 1'b0};
            if (!pix_en && now_v != snap) changes++;
            if (k <= 3)   check_output($sformatf("slow%0d.fs", k), frame_start, (k < 3) ? 1 : 0);
            if (k == 26)  check_output("slow26.ls", line_start, 1);
            if (k == 143) check_output("slow143.fs", frame_start, 0);
            if (k == 144) check_output("slow144.fs", frame_start, 1);
        end
        check_output("slow.hold_changes", changes, 0);
        pix_en = 1'b1;

        $display("[TB] mid-frame h_active rewrite");
        do_reset();
        apply_stimulus(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        enable = 1'b1;
        do_step();
        for (int i = 0; i <= 108; i++) begin
            sample(i);
            if (i == 10) h_active = CNT_W'(6);
            if (i < 108) do_step();
        end
        cnt = 0;
        for (int i = 0; i < 48; i++) cnt += cap_de[i];
        check_output("rew.frame1_de", cnt, 12);
        check_output("rew.fs48", cap_fs[48], 1);
        cnt = 0;
        fs_cnt = 0;
        for (int i = 48; i < 108; i++) begin
            cnt += cap_de[i];
            if (i > 48) fs_cnt += cap_fs[i];
        end
        check_output("rew.frame2_de", cnt, 18);
        check_output("rew.frame2_fs_inside", fs_cnt, 0);
        check_output("rew.fs108", cap_fs[108], 1);
        check_output("rew.x53", cap_x[53], 5);
        check_output("rew.hs55", cap_hs[55], 1);
        check_output("rew.hs54", cap_hs[54], 0);

        $display("[TB] configuration error");
        do_reset();
        apply_stimulus(4, 1, 0, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) do_step();
        check_output("err.cfg_err", cfg_err, 1);
        check_output("err.busy", busy, 0);
        check_output("err.de", de, 0);
        check_output("err.hsync", hsync, 1);
        check_output("err.vsync", vsync, 1);
        h_sync = CNT_W'(2);
        do_step();
        check_output("err.restart_busy", busy, 1);
        check_output("err.restart_cfg_err", cfg_err, 0);
        check_output("err.restart_fs", frame_start, 1);

        $display("[TB] stop at end of frame");
        do_reset();
        apply_stimulus(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        enable = 1'b1;
        do_step();
        for (int i = 0; i <= 50; i++) begin
            sample(i);
            if (i == 8) enable = 1'b0;
            if (i < 50) do_step();
        end
        check_output("stop.busy40", cap_busy[40], 1);
        check_output("stop.busy47", cap_busy[47], 1);
        check_output("stop.busy48", cap_busy[48], 0);
        check_output("stop.fs48", cap_fs[48], 0);
        check_output("stop.de48", cap_de[48], 0);
        check_output("stop.busy50", cap_busy[50], 0);

        $display("[TB] asynchronous reset mid-line");
        do_reset();
        enable = 1'b1;
        do_step();
        for (int i = 1; i <= 13; i++) begin
            do_step();
            if (i == 9) begin
                check_output("arst.pre_x", x, 1);
                check_output("arst.pre_y", y, 1);
            end
        end
        check_output("arst.pre_hsync", hsync, 1);
        check_output("arst.pre_busy", busy, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_output("arst.hsync", hsync, 0);
        check_output("arst.busy", busy, 0);
        check_output("arst.de", de, 0);
        check_output("arst.x", x, 0);
        check_output("arst.ls", line_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
